mpsoc_boot_loader: RTL and testbench
====================================

# mpsoc_boot_loader

Synthesizable multi-core boot sequencer for the OR1K MPSoC tile: it replaces bench-only ELF loading and global reset release with hardware behaviour. After `start_i`, it walks the selected cores in ascending index order. For each core it optionally clears that core's memory region, then streams image words from a ready/valid source into the region through a Wishbone classic master. Finally it releases the cores' resets one at a time with a programmable gap. It sits between the boot image source (host link or flash reader) and the tile interconnect, and drives the per-core reset lines.

## Interface
- `CORES_PER_TILE`, 8: number of cores; width of mask and reset vectors.
- `MEM_SIZE`, 32'h02000000: bytes per core memory region; the clear length is MEM_SIZE/4 words.
- `CORE_STRIDE`, 32'h02000000: byte distance between the bases of consecutive core regions.
- `AW`, 32: Wishbone address width.
- `RELEASE_GAP`, 16: cycles between successive core reset releases (≥1).

Ports:
- `wb_clk_i`  in  1  clock.
- `wb_rst_i`  in  1  reset. Synchronous, active-high.
- `start_i`  in  1  single-cycle start pulse. Ignored while `busy_o` is high.
- `clear_i`  in  1  clear each region before loading. Sampled on start.
- `core_mask_i`  in  CORES_PER_TILE  cores to load. Sampled on start.
- `img_base_i`  in  AW  byte offset of the image inside each region. Sampled on start.
- `img_words_i`  in  AW  words per core image. Sampled on start.
- `img_valid_i` / `img_data_i[31:0]` / `img_ready_o`: image stream. A word transfers when valid and ready are both high.
- `wbm_adr_o[AW-1:0]`, `wbm_dat_o[31:0]`, `wbm_sel_o[3:0]`, `wbm_we_o`, `wbm_cyc_o`, `wbm_stb_o`  out: Wishbone master outputs.
- `wbm_ack_i`, `wbm_err_i`  in: Wishbone master inputs.
- `cpu_rst_o`  out  CORES_PER_TILE  per-core reset, active-high.
- `busy_o`, `done_o`, `error_o`  out  1  status.

## Operation
- Values at reset:
  - `cpu_rst_o` = all ones.
  - `wbm_cyc_o` = `wbm_stb_o` = `wbm_we_o` = 0; `wbm_sel_o` = 0; `wbm_adr_o` = `wbm_dat_o` = 0.
  - `img_ready_o` = 0; `busy_o` = `done_o` = `error_o` = 0.
- States:
  - IDLE: on `start_i`, latch the inputs and set `cpu_rst_o` to all ones. Then:
    - if `img_words_i` > MEM_SIZE/4, go to ERROR;
    - else if the mask is zero, go to DONE;
    - else select the lowest set mask bit as core c and go to CLEAR if `clear_i` is set, otherwise to LOAD.
  - CLEAR: write 0 to word indexes 0..MEM_SIZE/4-1 at address `c*CORE_STRIDE + 4*i`, then go to LOAD.
  - LOAD: accept one stream word, write it to `c*CORE_STRIDE + img_base_i + 4*i`. Repeat for i = 0..img_words_i-1. If `img_words_i` = 0, go to NEXT immediately.
  - NEXT: select the next higher set mask bit and go to CLEAR or LOAD. If none remains, go to RELEASE.
  - RELEASE: clear `cpu_rst_o[c]` for masked cores in ascending order. The first release happens on entry; each later one follows RELEASE_GAP cycles after the previous. After the last release, go to DONE. Unmasked cores stay in reset.
  - DONE: `done_o` = 1 (level) until the next start.
  - ERROR: `error_o` = 1 (level); all `cpu_rst_o` = 1; cyc/stb dropped. Leave only on `start_i` or reset.
- Address arithmetic is modulo 2^AW, truncated with no error.
- `wbm_sel_o` = 4'hF and `wbm_we_o` = 1 during every write.
- `busy_o` is high in every state except IDLE, DONE and ERROR.
- A new `start_i` in DONE or ERROR clears `done_o`/`error_o` and restarts from the IDLE decision.

## Timing
- Bus cycle: cyc, stb, adr and dat are held stable until `wbm_ack_i` or `wbm_err_i`. On that cycle, drop cyc/stb in the next cycle; with no idle insertion, the next write may start in that same next cycle. Maximum throughput is 1 word per 2 cycles.
- `img_ready_o` is high only in LOAD while no bus cycle is outstanding and words remain. The word is captured at the handshake, and its bus cycle starts the next cycle.
- `wbm_err_i` takes priority over `wbm_ack_i` in the same cycle. It moves the block to ERROR on the next edge without advancing the word index.
- `wb_rst_i` mid-operation aborts immediately: all outputs return to their reset values on the next edge, including cyc dropped mid-transfer.
- Start-to-first-write latency is 2 cycles (latch, then cyc asserted).
- DONE follows 1 cycle after the last release.

## Test plan
- Mask 8'b0000_0101, clear 0, 4 words, base 0x100, ack after 1 cycle.
  - Writes go to 0x100..0x10C, then 0x02000100..0x0200010C.
  - `cpu_rst_o[0]` falls first and `cpu_rst_o[2]` falls 16 cycles later; the other bits stay 1; `done_o` rises.
- Clear 1, MEM_SIZE = 64, mask 1, 2 words: 16 zero writes precede the 2 image writes.
- Stalls: `img_valid_i` toggled randomly and ack delay 0–5 cycles.
  - Word order and data are preserved; no write occurs while stb is low.
- `wbm_err_i` on the 3rd write: `error_o` = 1, cyc drops, all resets are 1, and no further `img_ready_o` appears.
- `img_words_i` = MEM_SIZE/4+1: ERROR within 1 cycle and no bus activity. A mask of 0 gives DONE with all resets still 1.
- `wb_rst_i` asserted mid-LOAD while cyc is high: the next cycle shows all outputs at their reset values. A new start then reloads correctly.

Source files
------------

// File: rtl/mpsoc_boot_loader.sv
// Multi-core boot sequencer: optionally clears, then loads each selected core's memory
// region through a Wishbone classic master, and finally releases core resets one by one.
module mpsoc_boot_loader #(
   parameter int          CORES_PER_TILE = 8,
   parameter logic [31:0] MEM_SIZE       = 32'h0200_0000,
   parameter logic [31:0] CORE_STRIDE    = 32'h0200_0000,
   parameter int          AW             = 32,
   parameter int          RELEASE_GAP    = 16
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic                      start_i,
   input  logic                      clear_i,
   input  logic [CORES_PER_TILE-1:0] core_mask_i,
   input  logic [AW-1:0]             img_base_i,
   input  logic [AW-1:0]             img_words_i,
   input  logic                      img_valid_i,
   input  logic [31:0]               img_data_i,
   output logic                      img_ready_o,
   output logic [AW-1:0]             wbm_adr_o,
   output logic [31:0]               wbm_dat_o,
   output logic [3:0]                wbm_sel_o,
   output logic                      wbm_we_o,
   output logic                      wbm_cyc_o,
   output logic                      wbm_stb_o,
   input  logic                      wbm_ack_i,
   input  logic                      wbm_err_i,
   output logic [CORES_PER_TILE-1:0] cpu_rst_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      error_o
);

   localparam int CW = (CORES_PER_TILE > 1) ? $clog2(CORES_PER_TILE) : 1;
   localparam logic [AW-1:0] MEM_WORDS  = AW'(MEM_SIZE >> 2);
   localparam logic [15:0]   GAP_RELOAD = 16'(RELEASE_GAP - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CLEAR   = 3'd1;
   localparam logic [2:0] S_LOAD    = 3'd2;
   localparam logic [2:0] S_NEXT    = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;
   localparam logic [2:0] S_ERROR   = 3'd6;

   logic [2:0]                state;
   logic [CORES_PER_TILE-1:0] mask;
   logic [CORES_PER_TILE-1:0] pending;
   logic                      clear_en;
   logic [AW-1:0]             img_base;
   logic [AW-1:0]             img_words;
   logic [AW-1:0]             core_base;
   logic [AW-1:0]             cnt;
   logic [15:0]               gap;
   logic [CORES_PER_TILE-1:0] first_start;
   logic [CORES_PER_TILE-1:0] first_pending;
   logic [CORES_PER_TILE-1:0] first_mask;

   function automatic logic [CORES_PER_TILE-1:0] lowest_bit(input logic [CORES_PER_TILE-1:0] m);
      return m & (~m + CORES_PER_TILE'(1));
   endfunction

   function automatic logic [AW-1:0] base_of(input logic [CORES_PER_TILE-1:0] onehot);
      logic [CW-1:0] idx;
      idx = '0;
      for (int k = 0; k < CORES_PER_TILE; k++) begin
         if (onehot[k]) idx = CW'(k);
      end
      return AW'(idx) * AW'(CORE_STRIDE);
   endfunction

   assign first_start   = lowest_bit(core_mask_i);
   assign first_pending = lowest_bit(pending);
   assign first_mask    = lowest_bit(mask);

   assign img_ready_o = (state == S_LOAD) && !wbm_cyc_o && (cnt != img_words);
   assign busy_o      = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
   assign done_o      = (state == S_DONE);
   assign error_o     = (state == S_ERROR);

   // Sequencer state, bus master registers and per-core reset lines
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= S_IDLE;
         mask      <= '0;
         pending   <= '0;
         clear_en  <= 1'b0;
         img_base  <= '0;
         img_words <= '0;
         core_base <= '0;
         cnt       <= '0;
         gap       <= 16'd0;
         wbm_adr_o <= '0;
         wbm_dat_o <= 32'd0;
         wbm_sel_o <= 4'h0;
         wbm_we_o  <= 1'b0;
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         cpu_rst_o <= '1;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start_i) begin
                  mask      <= core_mask_i;
                  clear_en  <= clear_i;
                  img_base  <= img_base_i;
                  img_words <= img_words_i;
                  cnt       <= '0;
                  cpu_rst_o <= '1;
                  if (img_words_i > MEM_WORDS) begin
                     state <= S_ERROR;
                  end else if (core_mask_i == '0) begin
                     state <= S_DONE;
                  end else begin
                     pending   <= core_mask_i & ~first_start;
                     core_base <= base_of(first_start);
                     state     <= clear_i ? S_CLEAR : S_LOAD;
                  end
               end
            end
            S_CLEAR, S_LOAD: begin
               if (wbm_cyc_o) begin
                  // err wins over ack and leaves the word index untouched
                  if (wbm_err_i) begin
                     wbm_cyc_o <= 1'b0;
                     wbm_stb_o <= 1'b0;
                     wbm_we_o  <= 1'b0;
                     wbm_sel_o <= 4'h0;
                     cpu_rst_o <= '1;
                     state     <= S_ERROR;
                  end else if (wbm_ack_i) begin
                     wbm_cyc_o <= 1'b0;
                     wbm_stb_o <= 1'b0;
                     wbm_we_o  <= 1'b0;
                     wbm_sel_o <= 4'h0;
                     cnt       <= cnt + AW'(1);
                  end
               end else if (state == S_CLEAR) begin
                  if (cnt == MEM_WORDS) begin
                     cnt   <= '0;
                     state <= S_LOAD;
                  end else begin
                     wbm_cyc_o <= 1'b1;
                     wbm_stb_o <= 1'b1;
                     wbm_we_o  <= 1'b1;
                     wbm_sel_o <= 4'hF;
                     wbm_adr_o <= core_base + (cnt << 2);
                     wbm_dat_o <= 32'd0;
                  end
               end else if (cnt == img_words) begin
                  state <= S_NEXT;
               end else if (img_valid_i) begin
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  wbm_we_o  <= 1'b1;
                  wbm_sel_o <= 4'hF;
                  wbm_adr_o <= core_base + img_base + (cnt << 2);
                  wbm_dat_o <= img_data_i;
               end
            end
            S_NEXT: begin
               cnt <= '0;
               if (pending != '0) begin
                  pending   <= pending & ~first_pending;
                  core_base <= base_of(first_pending);
                  state     <= clear_en ? S_CLEAR : S_LOAD;
               end else begin
                  // the lowest masked core is released on the way into RELEASE
                  cpu_rst_o <= cpu_rst_o & ~first_mask;
                  pending   <= mask & ~first_mask;
                  gap       <= GAP_RELOAD;
                  state     <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (pending == '0) begin
                  state <= S_DONE;
               end else if (gap == 16'd0) begin
                  cpu_rst_o <= cpu_rst_o & ~first_pending;
                  pending   <= pending & ~first_pending;
                  gap       <= GAP_RELOAD;
               end else begin
                  gap <= gap - 16'd1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mpsoc_boot_loader.sv
// Self-checking bench for mpsoc_boot_loader: stream source, Wishbone slave responder and
// an address/data scoreboard filled when image words are queued.
module tb_mpsoc_boot_loader;
   localparam logic [31:0] STRIDE = 32'h0200_0000;
   localparam int          MWORDS = 16;

   logic        clk = 1'b0;
   logic        rst, start, clr, ivalid, iready;
   logic [7:0]  mask, cpu_rst;
   logic [31:0] ibase, iwords, idata, adr, dat;
   logic [3:0]  sel;
   logic        we, cyc, stb, ack, err, busy, done, err_st;

   int n_checks = 0;
   int n_pass   = 0;
   int wr_idx   = 0;
   int err_at   = 0;
   int cyc_seen = 0;
   int max_delay = 0;
   bit stall    = 1'b0;
   int cycle_cnt = 0;
   int fall_at [8];
   logic [7:0] prev_rst = 8'hFF;

   logic [31:0] src_q[$];
   logic [63:0] exp_q[$];

   mpsoc_boot_loader #(.MEM_SIZE(32'd64)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .clear_i(clr),
      .core_mask_i(mask), .img_base_i(ibase), .img_words_i(iwords),
      .img_valid_i(ivalid), .img_data_i(idata), .img_ready_o(iready),
      .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_sel_o(sel), .wbm_we_o(we),
      .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_ack_i(ack), .wbm_err_i(err),
      .cpu_rst_o(cpu_rst), .busy_o(busy), .done_o(done), .error_o(err_st)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   always @(negedge clk) begin
      prev_rst <= cpu_rst;
      for (int k = 0; k < 8; k++) begin
         if (prev_rst[k] && !cpu_rst[k]) fall_at[k] <= cycle_cnt;
      end
   end

   // Image stream source: pops a word once its handshake has happened
   initial begin : feeder
      bit fire;
      fire = 1'b0;
      ivalid = 1'b0;
      idata = 32'd0;
      forever begin
         @(negedge clk);
         if (fire && src_q.size() > 0) void'(src_q.pop_front());
         if (src_q.size() > 0) begin
            ivalid = stall ? 1'($urandom_range(1, 0)) : 1'b1;
            idata  = src_q[0];
         end else begin
            ivalid = 1'b0;
         end
         fire = ivalid && iready;
      end
   end

   // Wishbone slave: random ack delay, optional error, scoreboard check on each ack
   initial begin : responder
      bit          in_txn;
      int          wait_cnt, cur_delay;
      logic [31:0] cap_adr, cap_dat;
      logic [63:0] e;
      in_txn = 1'b0; wait_cnt = 0; cur_delay = 0; cap_adr = 32'd0; cap_dat = 32'd0;
      ack = 1'b0;
      err = 1'b0;
      forever begin
         @(negedge clk);
         ack = 1'b0;
         err = 1'b0;
         if (cyc || stb) begin
            n_checks++;
            if (cyc !== stb) $display("FAIL bus_cyc_stb got cyc=%b stb=%b want equal", cyc, stb); else n_pass++;
         end
         if (cyc && stb) begin
            cyc_seen++;
            if (!in_txn) begin
               in_txn = 1'b1; cap_adr = adr; cap_dat = dat; wait_cnt = 0;
               cur_delay = $urandom_range(max_delay, 0);
            end
            if (wait_cnt < cur_delay) begin
               wait_cnt++;
            end else begin
               in_txn = 1'b0;
               wr_idx++;
               if (wr_idx == err_at) begin
                  err = 1'b1;
               end else begin
                  ack = 1'b1;
                  n_checks++;
                  if ({adr, dat} !== {cap_adr, cap_dat}) $display("FAIL bus_stable got %h/%h want %h/%h", adr, dat, cap_adr, cap_dat); else n_pass++;
                  n_checks++;
                  if ({we, sel} !== 5'h1F) $display("FAIL bus_we_sel got we=%b sel=%h want we=1 sel=f", we, sel); else n_pass++;
                  n_checks++;
                  if (exp_q.size() == 0) begin
                     $display("FAIL sb_unexpected got write %h=%h want none", adr, dat);
                  end else begin
                     e = exp_q.pop_front();
                     if ({adr, dat} !== e) $display("FAIL sb_write got %h=%h want %h=%h", adr, dat, e[63:32], e[31:0]); else n_pass++;
                  end
               end
            end
         end else begin
            in_txn = 1'b0;
         end
      end
   end

   task automatic do_start(input logic [7:0] m, input logic c, input logic [31:0] b, input logic [31:0] w, input bit push);
      logic [31:0] d;
      @(negedge clk);
      if (push) begin
         for (int k = 0; k < 8; k++) begin
            if (m[k]) begin
               if (c) for (int i = 0; i < MWORDS; i++) exp_q.push_back({32'(k) * STRIDE + 32'(4 * i), 32'd0});
               for (int i = 0; i < int'(w); i++) begin
                  d = $urandom;
                  src_q.push_back(d);
                  exp_q.push_back({32'(k) * STRIDE + b + 32'(4 * i), d});
               end
            end
         end
      end
      mask = m; clr = c; ibase = b; iwords = w; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(input int budget, output bit hit);
      hit = 1'b0;
      for (int k = 0; k < budget && !hit; k++) begin
         @(negedge clk);
         if (done || err_st) hit = 1'b1;
      end
   endtask

   task automatic flush();
      src_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({cyc, stb, we, sel, adr, dat} !== 71'd0) $display("FAIL reset_bus got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h want 0", cyc, stb, we, sel, adr, dat); else n_pass++;
      n_checks++;
      if ({cpu_rst, iready, busy, done, err_st} !== 12'hFF0) $display("FAIL reset_status got rst=%h rdy=%b busy=%b done=%b err=%b want ff/0", cpu_rst, iready, busy, done, err_st); else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_basic_load();
      bit hit;
      int w0;
      w0 = wr_idx;
      stall = 1'b0; max_delay = 0;
      do_start(8'b0000_0101, 1'b0, 32'h100, 32'd4, 1'b1);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else n_pass++;
      wait_end(300, hit);
      n_checks++;
      if (!hit || done !== 1'b1 || err_st !== 1'b0) $display("FAIL basic_done got done=%b err=%b want 1/0", done, err_st); else n_pass++;
      n_checks++;
      if (cpu_rst !== 8'b1111_1010) $display("FAIL basic_cpu_rst got %b want 11111010", cpu_rst); else n_pass++;
      n_checks++;
      if (fall_at[2] - fall_at[0] != 16) $display("FAIL basic_gap got %0d want 16", fall_at[2] - fall_at[0]); else n_pass++;
      n_checks++;
      if (wr_idx - w0 != 8 || exp_q.size() != 0) $display("FAIL basic_writes got %0d left=%0d want 8 left=0", wr_idx - w0, exp_q.size()); else n_pass++;
      repeat (3) @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0) $display("FAIL basic_done_level got done=%b busy=%b want 1/0", done, busy); else n_pass++;
   endtask

   task automatic test_clear();
      bit hit;
      int w0;
      w0 = wr_idx;
      do_start(8'b0000_0001, 1'b1, 32'h20, 32'd2, 1'b1);
      wait_end(300, hit);
      n_checks++;
      if (!hit || done !== 1'b1) $display("FAIL clear_done got done=%b want 1", done); else n_pass++;
      n_checks++;
      if (wr_idx - w0 != 18 || exp_q.size() != 0) $display("FAIL clear_writes got %0d left=%0d want 18 left=0", wr_idx - w0, exp_q.size()); else n_pass++;
      n_checks++;
      if (cpu_rst !== 8'hFE) $display("FAIL clear_cpu_rst got %h want fe", cpu_rst); else n_pass++;
   endtask

   task automatic test_stalls();
      bit hit;
      stall = 1'b1; max_delay = 5;
      do_start(8'b1000_0010, 1'b0, 32'h40, 32'd6, 1'b1);
      wait_end(600, hit);
      n_checks++;
      if (!hit || done !== 1'b1) $display("FAIL stall_done got done=%b want 1", done); else n_pass++;
      n_checks++;
      if (exp_q.size() != 0 || src_q.size() != 0) $display("FAIL stall_drain got exp=%0d src=%0d want 0/0", exp_q.size(), src_q.size()); else n_pass++;
      n_checks++;
      if (cpu_rst !== 8'b0111_1101) $display("FAIL stall_cpu_rst got %b want 01111101", cpu_rst); else n_pass++;
      stall = 1'b0; max_delay = 0;
   endtask

   task automatic test_bus_error();
      bit hit;
      int rdy_seen;
      max_delay = 1;
      err_at = wr_idx + 3;
      do_start(8'b0000_0001, 1'b0, 32'h0, 32'd5, 1'b1);
      wait_end(200, hit);
      n_checks++;
      if (!hit || err_st !== 1'b1 || done !== 1'b0) $display("FAIL err_flag got err=%b done=%b want 1/0", err_st, done); else n_pass++;
      n_checks++;
      if (cyc !== 1'b0 || stb !== 1'b0 || busy !== 1'b0) $display("FAIL err_bus got cyc=%b stb=%b busy=%b want 0", cyc, stb, busy); else n_pass++;
      n_checks++;
      if (cpu_rst !== 8'hFF) $display("FAIL err_cpu_rst got %h want ff", cpu_rst); else n_pass++;
      n_checks++;
      if (exp_q.size() != 3) $display("FAIL err_progress got %0d pending want 3", exp_q.size()); else n_pass++;
      rdy_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (iready) rdy_seen++;
      end
      n_checks++;
      if (rdy_seen != 0 || err_st !== 1'b1) $display("FAIL err_no_ready got %0d ready err=%b want 0/1", rdy_seen, err_st); else n_pass++;
      flush();
      err_at = 0; max_delay = 0;
   endtask

   task automatic test_overflow_and_empty();
      int c0;
      c0 = cyc_seen;
      do_start(8'b0000_0001, 1'b0, 32'h0, 32'(MWORDS + 1), 1'b0);
      n_checks++;
      if (err_st !== 1'b1 || busy !== 1'b0) $display("FAIL ovf_error got err=%b busy=%b want 1/0", err_st, busy); else n_pass++;
      repeat (5) @(negedge clk);
      n_checks++;
      if (cyc_seen != c0 || err_st !== 1'b1) $display("FAIL ovf_no_bus got %0d cycles err=%b want 0/1", cyc_seen - c0, err_st); else n_pass++;
      do_start(8'h00, 1'b0, 32'h0, 32'd4, 1'b0);
      n_checks++;
      if (done !== 1'b1 || err_st !== 1'b0) $display("FAIL empty_done got done=%b err=%b want 1/0", done, err_st); else n_pass++;
      n_checks++;
      if (cpu_rst !== 8'hFF || cyc_seen != c0) $display("FAIL empty_state got rst=%h bus=%0d want ff/0", cpu_rst, cyc_seen - c0); else n_pass++;
   endtask

   task automatic test_reset_mid_load();
      bit hit;
      int k;
      max_delay = 4;
      do_start(8'b0000_0100, 1'b0, 32'h0, 32'd4, 1'b1);
      k = 0;
      while (!(cyc && dut.state == 3'd2) && k < 50) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (cyc !== 1'b1) $display("FAIL midrst_cyc got %b want 1", cyc); else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({cyc, stb, we, sel, adr, dat} !== 71'd0) $display("FAIL midrst_bus got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h want 0", cyc, stb, we, sel, adr, dat); else n_pass++;
      n_checks++;
      if ({cpu_rst, iready, busy, done, err_st} !== 12'hFF0) $display("FAIL midrst_status got rst=%h rdy=%b busy=%b done=%b err=%b want ff/0", cpu_rst, iready, busy, done, err_st); else n_pass++;
      flush();
      @(negedge clk);
      rst = 1'b0;
      max_delay = 2;
      do_start(8'b0000_0100, 1'b0, 32'h0, 32'd4, 1'b1);
      wait_end(300, hit);
      n_checks++;
      if (!hit || done !== 1'b1 || exp_q.size() != 0) $display("FAIL reload_done got done=%b left=%0d want 1/0", done, exp_q.size()); else n_pass++;
      n_checks++;
      if (cpu_rst !== 8'hFB) $display("FAIL reload_cpu_rst got %h want fb", cpu_rst); else n_pass++;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; clr = 1'b0; mask = 8'h00; ibase = 32'd0; iwords = 32'd0;
      for (int k = 0; k < 8; k++) fall_at[k] = 0;
      test_reset();
      test_basic_load();
      test_clear();
      test_stalls();
      test_bus_error();
      test_overflow_and_empty();
      test_reset_mid_load();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
